// File: rtl/seat_pkg.sv
// Shared types and constants for the seat-table request issuer.
package seat_pkg;

  localparam int TIME_W = 11;
  localparam int NUM_SEATS = 32;
  localparam int SEAT_W = $clog2(NUM_SEATS);
  localparam logic [1:0] BAN_NONE = 2'd2;

  typedef enum logic [1:0] {
    OUT    = 2'd0,
    IN     = 2'd1,
    AWAY   = 2'd2,
    BANNED = 2'd3
  } seat_state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    SET_BAN   = 2'd1,
    SET_LIMIT = 2'd2,
    CLEAR     = 2'd3
  } mgr_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_CLR = 3'd1,
    S_ISSUE_SET = 3'd2,
    S_ISSUE_REQ = 3'd3,
    S_GAP       = 3'd4
  } issuer_state_e;

  typedef struct packed {
    logic [31:0]       student_no;
    logic [SEAT_W-1:0] seat_no;
    seat_state_e       state;
  } seat_req_t;

  // Code 3 is reserved on the table side and must never be written by a student.
  function automatic logic is_legal(input seat_state_e s);
    return (s != BANNED);
  endfunction

endpackage

// File: rtl/seat_req_fifo.sv
// Synchronous FIFO of student requests with registered full/empty flags.
module seat_req_fifo
  import seat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  seat_req_t din,
  output seat_req_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = (AW + 1)'(0);

  seat_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign head = mem[rd_ptr];

  // Occupancy after this cycle; a flush also discards a same-cycle push.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (flush) begin
      count_next = CNT_ZERO;
    end else begin
      count_next = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= CNT_ZERO;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(do_push);
        rd_ptr <= rd_ptr + AW'(do_pop);
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == CNT_ZERO);
    end
  end

endmodule

// File: rtl/seat_request_issuer.sv
// Serialises kiosk requests and manager commands into single-cycle seat-table
// write transactions, and owns the table's time base.
module seat_request_issuer
  import seat_pkg::*;
#(
  parameter int              FIFO_DEPTH  = 4,
  parameter int              TICK_DIV    = 1000,
  parameter logic [TIME_W-1:0] LIMIT_RESET = 11'd120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_student_no,
  input  logic [4:0]        req_seat_no,
  input  logic [1:0]        req_state,
  output logic              req_err,
  input  logic              mgr_valid,
  output logic              mgr_ready,
  input  logic [1:0]        mgr_cmd,
  input  logic [1:0]        mgr_ban,
  input  logic [10:0]       mgr_limit,
  output logic              write_mem,
  output logic [31:0]       Student_No_mem,
  output logic [4:0]        Seat_No_mem,
  output logic [1:0]        Seat_State_mem,
  output logic [10:0]       Time_mem,
  output logic [1:0]        write_set_mem,
  output logic [10:0]       limit_time_mem,
  output logic [1:0]        ban_mem,
  output logic              rst_mem
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  issuer_state_e     state, state_next;
  mgr_cmd_e          pend, pend_next;
  logic [1:0]        pend_ban, pend_ban_next;
  logic [TIME_W-1:0] pend_limit, pend_limit_next;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  seat_req_t         fifo_din, fifo_head;
  logic              mgr_fire;
  logic              write_mem_next, rst_mem_next, req_err_next, mgr_ready_next;
  logic [1:0]        write_set_next, ban_next, sstate_next;
  logic [TIME_W-1:0] limit_next;
  logic [31:0]       stu_next;
  logic [4:0]        seat_next;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign mgr_fire  = mgr_valid && mgr_ready;
  assign tick      = (presc == PRESC_MAX);
  assign fifo_din  = '{student_no: req_student_no, seat_no: req_seat_no,
                       state: seat_state_e'(req_state)};

  seat_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Free-running time base; wraps at 2048 and is untouched by a table clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      Time_mem <= 11'd0;
    end else if (tick) begin
      presc    <= '0;
      Time_mem <= Time_mem + 11'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // Next state and next output values; strobes appear the cycle after an ISSUE state.
  always_comb begin
    state_next      = state;
    pend_next       = pend;
    pend_ban_next   = pend_ban;
    pend_limit_next = pend_limit;
    write_mem_next  = 1'b0;
    write_set_next  = 2'd0;
    rst_mem_next    = 1'b0;
    req_err_next    = 1'b0;
    ban_next        = ban_mem;
    limit_next      = limit_time_mem;
    stu_next        = Student_No_mem;
    seat_next       = Seat_No_mem;
    sstate_next     = Seat_State_mem;
    fifo_pop        = 1'b0;
    fifo_flush      = 1'b0;

    if (mgr_fire && (mgr_cmd != 2'd0)) begin
      pend_next       = mgr_cmd_e'(mgr_cmd);
      pend_ban_next   = mgr_ban;
      pend_limit_next = mgr_limit;
    end else begin
      pend_next = pend_next;
    end

    case (state)
      S_IDLE: begin
        if (pend == CLEAR) begin
          state_next = S_ISSUE_CLR;
        end else if (pend == SET_BAN) begin
          ban_next   = pend_ban;
          state_next = S_ISSUE_SET;
        end else if (pend == SET_LIMIT) begin
          limit_next = pend_limit;
          state_next = S_ISSUE_SET;
        end else if (!fifo_empty) begin
          state_next = S_ISSUE_REQ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE_CLR: begin
        rst_mem_next = 1'b1;
        fifo_flush   = 1'b1;
        pend_next    = NONE;
        state_next   = S_GAP;
      end
      S_ISSUE_SET: begin
        write_set_next = (pend == SET_BAN) ? 2'd1 : 2'd2;
        pend_next      = NONE;
        state_next     = S_GAP;
      end
      S_ISSUE_REQ: begin
        fifo_pop = 1'b1;
        if (is_legal(fifo_head.state)) begin
          write_mem_next = 1'b1;
          stu_next       = fifo_head.student_no;
          seat_next      = fifo_head.seat_no;
          sstate_next    = fifo_head.state;
          state_next     = S_GAP;
        end else begin
          req_err_next = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    mgr_ready_next = (state_next == S_IDLE) && (pend_next == NONE);
  end

  // State, latched manager command and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pend           <= NONE;
      pend_ban       <= BAN_NONE;
      pend_limit     <= LIMIT_RESET;
      mgr_ready      <= 1'b1;
      write_mem      <= 1'b0;
      write_set_mem  <= 2'd0;
      rst_mem        <= 1'b0;
      req_err        <= 1'b0;
      ban_mem        <= BAN_NONE;
      limit_time_mem <= LIMIT_RESET;
      Student_No_mem <= 32'd0;
      Seat_No_mem    <= 5'd0;
      Seat_State_mem <= 2'd0;
    end else begin
      state          <= state_next;
      pend           <= pend_next;
      pend_ban       <= pend_ban_next;
      pend_limit     <= pend_limit_next;
      mgr_ready      <= mgr_ready_next;
      write_mem      <= write_mem_next;
      write_set_mem  <= write_set_next;
      rst_mem        <= rst_mem_next;
      req_err        <= req_err_next;
      ban_mem        <= ban_next;
      limit_time_mem <= limit_next;
      Student_No_mem <= stu_next;
      Seat_No_mem    <= seat_next;
      Seat_State_mem <= sstate_next;
    end
  end

endmodule

// File: tb/tb_seat_request_issuer.sv
// Directed bench for seat_request_issuer with a transaction-level scoreboard.
module tb_seat_request_issuer;

  localparam int TICK = 4;
  localparam byte EV_W = 8'h57;
  localparam byte EV_S = 8'h53;
  localparam byte EV_C = 8'h43;
  localparam byte EV_E = 8'h45;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_err;
  logic [31:0] req_student_no;
  logic [4:0]  req_seat_no;
  logic [1:0]  req_state;
  logic        mgr_valid, mgr_ready;
  logic [1:0]  mgr_cmd, mgr_ban;
  logic [10:0] mgr_limit;
  logic        write_mem, rst_mem;
  logic [31:0] Student_No_mem;
  logic [4:0]  Seat_No_mem;
  logic [1:0]  Seat_State_mem, write_set_mem, ban_mem;
  logic [10:0] Time_mem, limit_time_mem;

  seat_request_issuer #(.FIFO_DEPTH(4), .TICK_DIV(TICK), .LIMIT_RESET(11'd120)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_student_no(req_student_no), .req_seat_no(req_seat_no), .req_state(req_state),
    .req_err(req_err),
    .mgr_valid(mgr_valid), .mgr_ready(mgr_ready), .mgr_cmd(mgr_cmd),
    .mgr_ban(mgr_ban), .mgr_limit(mgr_limit),
    .write_mem(write_mem), .Student_No_mem(Student_No_mem), .Seat_No_mem(Seat_No_mem),
    .Seat_State_mem(Seat_State_mem), .Time_mem(Time_mem), .write_set_mem(write_set_mem),
    .limit_time_mem(limit_time_mem), .ban_mem(ban_mem), .rst_mem(rst_mem)
  );

  typedef struct { longint stu; int seat; int st; } req_t;
  typedef struct { int cmd; int ban; int lim; } mgr_t;

  int     errors = 0;
  int     checks = 0;
  req_t   model_q[$];
  mgr_t   mgr_q[$];
  byte    evlog[$];
  int     ticks = 0;
  logic   rst_seen = 1'b0;
  int     since = 100;
  longint last_stu = 0;
  int     last_seat = 0, last_st = 0;
  int     held_ban = 2, held_lim = 120;
  int     prev_ban = 2, prev_lim = 120;
  int     waits[5];
  req_t   r;
  mgr_t   m;
  int     nstb;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: posedge tracks reset/time, negedge checks outputs and records handshakes.
  initial begin : monitor
    forever begin
      @(clk);
      if (clk) begin
        rst_seen = rst_n;
        if (!rst_n) begin
          ticks = 0; model_q.delete(); mgr_q.delete();
          last_stu = 0; last_seat = 0; last_st = 0;
          held_ban = 2; held_lim = 120; since = 100;
        end else begin
          ticks++;
        end
      end else begin
        if (!rst_seen) begin
          chk("rst_write_mem", write_mem, 0);
          chk("rst_write_set", write_set_mem, 0);
          chk("rst_rst_mem", rst_mem, 0);
          chk("rst_req_err", req_err, 0);
          chk("rst_time", Time_mem, 0);
          chk("rst_student", Student_No_mem, 0);
          chk("rst_seat", Seat_No_mem, 0);
          chk("rst_state", Seat_State_mem, 0);
          chk("rst_ban", ban_mem, 2);
          chk("rst_limit", limit_time_mem, 120);
        end else begin
          since++;
          chk("time", Time_mem, (ticks / TICK) % 2048);
          nstb = int'(write_mem) + int'(write_set_mem != 2'd0) + int'(rst_mem);
          chk("one_strobe", nstb <= 1, 1);
          chk("err_alone", req_err && (nstb != 0), 0);
          if (nstb != 0) begin
            chk("spacing", since >= 3, 1);
            since = 0;
          end
          if (write_mem) begin
            evlog.push_back(EV_W);
            if (model_q.size() == 0) chk("write_unexpected", 1, 0);
            else begin
              r = model_q.pop_front();
              chk("write_legal", r.st != 3, 1);
              last_stu = r.stu; last_seat = r.seat; last_st = r.st;
            end
          end
          if (req_err) begin
            evlog.push_back(EV_E);
            if (model_q.size() == 0) chk("err_unexpected", 1, 0);
            else begin
              r = model_q.pop_front();
              chk("err_state", r.st, 3);
            end
          end
          if (write_set_mem != 2'd0) begin
            evlog.push_back(EV_S);
            if (mgr_q.size() == 0) chk("set_unexpected", 1, 0);
            else begin
              m = mgr_q.pop_front();
              chk("set_kind", write_set_mem, m.cmd);
              if (m.cmd == 1) begin
                chk("set_ban", ban_mem, m.ban);
                chk("set_ban_settled", prev_ban, m.ban);
                held_ban = m.ban;
              end else begin
                chk("set_limit", limit_time_mem, m.lim);
                chk("set_limit_settled", prev_lim, m.lim);
                held_lim = m.lim;
              end
            end
          end
          if (rst_mem) begin
            evlog.push_back(EV_C);
            if (mgr_q.size() == 0) chk("clear_unexpected", 1, 0);
            else begin
              m = mgr_q.pop_front();
              chk("clear_kind", m.cmd, 3);
            end
            model_q.delete();
          end
          chk("hold_student", Student_No_mem, last_stu);
          chk("hold_seat", Seat_No_mem, last_seat);
          chk("hold_state", Seat_State_mem, last_st);
          if (mgr_q.size() == 0) begin
            chk("hold_ban", ban_mem, held_ban);
            chk("hold_limit", limit_time_mem, held_lim);
          end
        end
        if (rst_n && req_valid && req_ready)
          model_q.push_back('{stu: req_student_no, seat: req_seat_no, st: req_state});
        if (rst_n && mgr_valid && mgr_ready && mgr_cmd != 2'd0)
          mgr_q.push_back('{cmd: mgr_cmd, ban: mgr_ban, lim: mgr_limit});
        prev_ban = ban_mem;
        prev_lim = limit_time_mem;
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint stu, input int seat, input int st, output int w);
    req_student_no = stu[31:0];
    req_seat_no = seat[4:0];
    req_state = st[1:0];
    req_valid = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w = i;
        return;
      end
    end
    chk("push_timeout", 0, 1);
    req_valid = 1'b0;
    w = 99;
  endtask

  task automatic mgr_send(input int cmd, input int ban, input int lim);
    mgr_cmd = cmd[1:0];
    mgr_ban = ban[1:0];
    mgr_limit = lim[10:0];
    mgr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mgr_ready) begin
        @(posedge clk);
        #1;
        mgr_valid = 1'b0;
        return;
      end
    end
    chk("mgr_timeout", 0, 1);
    mgr_valid = 1'b0;
  endtask

  task automatic wait_events(input int n);
    for (int i = 0; i < 80 && evlog.size() < n; i++) @(negedge clk);
    repeat (6) @(negedge clk);
  endtask

  initial begin : stim
    int w, found, nw;
    rst_n = 1'b0; req_valid = 1'b0; mgr_valid = 1'b0;
    req_student_no = 32'd0; req_seat_no = 5'd0; req_state = 2'd0;
    mgr_cmd = 2'd0; mgr_ban = 2'd0; mgr_limit = 11'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle time base
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("idle_time10", Time_mem, 10);
    chk("idle_ban", ban_mem, 2);
    chk("idle_limit", limit_time_mem, 120);
    chk("idle_strobes", {write_mem, write_set_mem, rst_mem}, 0);
    chk("idle_mgr_ready", mgr_ready, 1);

    // Single request
    evlog.delete();
    align();
    push(20231234, 5, 1, w);
    chk("single_nostall", w, 1);
    found = 0;
    for (int i = 1; i <= 3 && found == 0; i++) begin
      @(negedge clk);
      if (write_mem) begin
        found = 1;
        chk("single_student", Student_No_mem, 20231234);
        chk("single_seat", Seat_No_mem, 5);
        chk("single_state", Seat_State_mem, 1);
      end
      chk("single_ready", req_ready, 1);
    end
    chk("single_latency", found, 1);
    @(negedge clk);
    chk("single_pulse_width", write_mem, 0);
    wait_events(1);
    chk("single_count", evlog.size(), 1);

    // Ban ahead of five queued requests, fifth stalls on full FIFO
    evlog.delete();
    align();
    fork
      mgr_send(1, 1, 0);
      begin
        push(101, 1, 1, waits[0]);
        push(102, 2, 2, waits[1]);
        push(103, 3, 0, waits[2]);
        push(104, 4, 1, waits[3]);
        push(105, 31, 2, waits[4]);
      end
    join
    for (int k = 0; k < 4; k++) chk("burst_nostall", waits[k], 1);
    chk("fifth_stall", waits[4] > 1, 1);
    wait_events(6);
    chk("burst_events", evlog.size(), 6);
    chk("ban_first", evlog[0], EV_S);
    nw = 0;
    foreach (evlog[k]) if (evlog[k] == EV_W) nw++;
    chk("burst_writes", nw, 5);
    chk("ban_held", ban_mem, 1);
    chk("burst_last_seat", Seat_No_mem, 31);

    // Limit ahead of two requests
    evlog.delete();
    align();
    fork
      mgr_send(2, 0, 500);
      begin
        push(201, 7, 1, w);
        push(202, 8, 0, w);
      end
    join
    wait_events(3);
    chk("limit_events", evlog.size(), 3);
    chk("limit_first", evlog[0], EV_S);
    chk("limit_held", limit_time_mem, 500);

    // Clear flushes queued and coincident pushes
    evlog.delete();
    align();
    fork
      mgr_send(3, 0, 0);
      begin
        push(301, 11, 1, w);
        push(302, 12, 1, w);
        push(303, 13, 2, w);
      end
    join
    wait_events(1);
    repeat (10) @(negedge clk);
    chk("clear_events", evlog.size(), 1);
    chk("clear_only", evlog[0], EV_C);
    chk("clear_fifo_empty", model_q.size(), 0);
    chk("clear_keeps_ban", ban_mem, 1);

    // Ignored manager command and illegal request
    evlog.delete();
    align();
    mgr_send(0, 1, 7);
    push(401, 9, 3, w);
    wait_events(1);
    chk("illegal_events", evlog.size(), 1);
    chk("illegal_err", evlog[0], EV_E);
    chk("illegal_student_held", Student_No_mem, 202);

    // Reset during ISSUE_REQ drops the transaction
    evlog.delete();
    align();
    push(501, 10, 1, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_write", write_mem, 0);
    chk("midrst_student", Student_No_mem, 0);
    chk("midrst_time", Time_mem, 0);
    chk("midrst_ban", ban_mem, 2);
    chk("midrst_limit", limit_time_mem, 120);

    // Time wrap 2047 -> 0
    repeat (8188) @(posedge clk);
    @(negedge clk);
    chk("time_2047", Time_mem, 2047);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("time_wrap0", Time_mem, 0);
    chk("midrst_no_events", evlog.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
